// File: rtl/friscv_axi_rd_arbiter.sv
// friscv_axi_rd_arbiter: round-robin 2:1 AXI4 read-channel arbiter, one burst outstanding at a time.
module friscv_axi_rd_arbiter #(
    parameter int ADDRW     = 16,
    parameter int AXI_IDW   = 8,
    parameter int AXI_DATAW = 128
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 srst,
    input  logic                 s0_axi_arvalid,
    output logic                 s0_axi_arready,
    input  logic [ADDRW-1:0]     s0_axi_araddr,
    input  logic [7:0]           s0_axi_arlen,
    input  logic [2:0]           s0_axi_arsize,
    input  logic [1:0]           s0_axi_arburst,
    input  logic [1:0]           s0_axi_arlock,
    input  logic [3:0]           s0_axi_arcache,
    input  logic [2:0]           s0_axi_arprot,
    input  logic [AXI_IDW-1:0]   s0_axi_arid,
    output logic                 s0_axi_rvalid,
    input  logic                 s0_axi_rready,
    output logic [AXI_DATAW-1:0] s0_axi_rdata,
    output logic [1:0]           s0_axi_rresp,
    output logic [AXI_IDW-1:0]   s0_axi_rid,
    output logic                 s0_axi_rlast,
    input  logic                 s1_axi_arvalid,
    output logic                 s1_axi_arready,
    input  logic [ADDRW-1:0]     s1_axi_araddr,
    input  logic [7:0]           s1_axi_arlen,
    input  logic [2:0]           s1_axi_arsize,
    input  logic [1:0]           s1_axi_arburst,
    input  logic [1:0]           s1_axi_arlock,
    input  logic [3:0]           s1_axi_arcache,
    input  logic [2:0]           s1_axi_arprot,
    input  logic [AXI_IDW-1:0]   s1_axi_arid,
    output logic                 s1_axi_rvalid,
    input  logic                 s1_axi_rready,
    output logic [AXI_DATAW-1:0] s1_axi_rdata,
    output logic [1:0]           s1_axi_rresp,
    output logic [AXI_IDW-1:0]   s1_axi_rid,
    output logic                 s1_axi_rlast,
    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,
    output logic [ADDRW-1:0]     m_axi_araddr,
    output logic [7:0]           m_axi_arlen,
    output logic [2:0]           m_axi_arsize,
    output logic [1:0]           m_axi_arburst,
    output logic [1:0]           m_axi_arlock,
    output logic [3:0]           m_axi_arcache,
    output logic [2:0]           m_axi_arprot,
    output logic [AXI_IDW-1:0]   m_axi_arid,
    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready,
    input  logic [AXI_DATAW-1:0] m_axi_rdata,
    input  logic [1:0]           m_axi_rresp,
    input  logic [AXI_IDW-1:0]   m_axi_rid,
    input  logic                 m_axi_rlast
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t state, state_nxt;
    logic   grant, grant_nxt, last, last_nxt;

    // last resets to 1 so master 0 wins the first tie
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
        end else if (srst) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        case (state)
            IDLE: if (s0_axi_arvalid | s1_axi_arvalid) begin
                grant_nxt = (s0_axi_arvalid & s1_axi_arvalid) ? ~last : s1_axi_arvalid;
                state_nxt = ADDR;
            end
            ADDR: if (m_axi_arvalid & m_axi_arready) state_nxt = DATA;
            DATA: if (m_axi_rvalid & m_axi_rready & m_axi_rlast) begin
                last_nxt  = grant;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_axi_arvalid  = (state == ADDR) && (grant ? s1_axi_arvalid : s0_axi_arvalid);
        m_axi_araddr   = grant ? s1_axi_araddr  : s0_axi_araddr;
        m_axi_arlen    = grant ? s1_axi_arlen   : s0_axi_arlen;
        m_axi_arsize   = grant ? s1_axi_arsize  : s0_axi_arsize;
        m_axi_arburst  = grant ? s1_axi_arburst : s0_axi_arburst;
        m_axi_arlock   = grant ? s1_axi_arlock  : s0_axi_arlock;
        m_axi_arcache  = grant ? s1_axi_arcache : s0_axi_arcache;
        m_axi_arprot   = grant ? s1_axi_arprot  : s0_axi_arprot;
        m_axi_arid     = grant ? s1_axi_arid    : s0_axi_arid;
        s0_axi_arready = (state == ADDR) && !grant && m_axi_arready;
        s1_axi_arready = (state == ADDR) &&  grant && m_axi_arready;
        m_axi_rready   = (state == DATA) && (grant ? s1_axi_rready : s0_axi_rready);
        s0_axi_rvalid  = (state == DATA) && !grant && m_axi_rvalid;
        s1_axi_rvalid  = (state == DATA) &&  grant && m_axi_rvalid;
        // R payload fans out to both; only the owner's rvalid qualifies it
        s0_axi_rdata   = m_axi_rdata;
        s0_axi_rresp   = m_axi_rresp;
        s0_axi_rid     = m_axi_rid;
        s0_axi_rlast   = m_axi_rlast;
        s1_axi_rdata   = m_axi_rdata;
        s1_axi_rresp   = m_axi_rresp;
        s1_axi_rid     = m_axi_rid;
        s1_axi_rlast   = m_axi_rlast;
    end

endmodule

// File: doc/friscv_axi_rd_arbiter.md
# friscv_axi_rd_arbiter

Two-to-one AXI4 read-channel arbiter that shares a single memory read port between the instruction cache (master 0) and the data cache (master 1). It sits between the caches' AR/R channels and the AXI RAM/interconnect read port. Grants alternate round-robin, one burst at a time. Read data is returned only to the master that owns the burst in flight.

## Interface
- ADDRW, 16, AXI address width
- AXI_IDW, 8, AXI ID width (IDs are passed through unmodified)
- AXI_DATAW, 128, AXI data width
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- srst  in  1  synchronous active-high soft reset; same effect as areset, applied at the next aclk edge
- s0_axi_arvalid / s0_axi_arready  in / out  1  master 0 (icache) AR handshake
- s0_axi_araddr, arlen, arsize, arburst, arlock, arcache, arprot, arid  in  ADDRW, 8, 3, 2, 2, 4, 3, AXI_IDW  master 0 AR payload
- s0_axi_rvalid / s0_axi_rready  out / in  1  master 0 R handshake
- s0_axi_rdata, rresp, rid, rlast  out  AXI_DATAW, 2, AXI_IDW, 1  master 0 R payload
- s1_axi_* : same set as s0, for master 1 (dcache)
- m_axi_arvalid / m_axi_arready  out / in  1  shared port AR handshake
- m_axi_araddr, arlen, arsize, arburst, arlock, arcache, arprot, arid  out  same widths as s0 AR payload
- m_axi_rvalid / m_axi_rready  in / out  1  shared port R handshake
- m_axi_rdata, rresp, rid, rlast  in  AXI_DATAW, 2, AXI_IDW, 1  shared port R payload

## Operation
- FSM states: IDLE, ADDR, DATA. Registers: `grant` (1 bit, owner of current burst) and `last` (1 bit, last master served).
- IDLE:
  - If exactly one sN_axi_arvalid is high, grant = N.
  - If both are high, grant = ~last.
  - When any request is present, go to ADDR. Otherwise stay in IDLE.
  - All arready and rvalid outputs are 0 in IDLE.
- ADDR:
  - m_axi_ar* is the combinational pass-through of s[grant]_axi_ar*.
  - s[grant]_axi_arready = m_axi_arready. The non-granted arready is 0.
  - On m_axi_arvalid & m_axi_arready, go to DATA.
- DATA:
  - s[grant]_axi_r* = m_axi_r*, and m_axi_rready = s[grant]_axi_rready.
  - The non-granted master sees rvalid = 0. Its R payload outputs are driven with the shared values, and it must ignore them.
  - m_axi_arvalid = 0.
  - On m_axi_rvalid & m_axi_rready & m_axi_rlast, set last = grant and go to IDLE.
- Exactly one burst is outstanding at any time. arid, rid and rresp are not modified.
- A granted master must keep arvalid asserted until the AR handshake completes (AXI rule). The arbiter does not re-arbitrate in ADDR.
- A request from the non-granted master during ADDR or DATA waits; its arready stays 0.

## Timing
- Reset (areset or srst):
  - state = IDLE, grant = 0, last = 1, so master 0 wins the first tie.
  - All arready, rvalid, m_axi_arvalid and m_axi_rready are 0.
- Latency from sN arvalid rising in IDLE to m_axi_arvalid: 1 cycle (registered grant). The AR payload itself adds no cycles.
- R path: 0 cycles, fully combinational in DATA.
- Turnaround: after the rlast beat, at least one IDLE cycle before the next ADDR. Back-to-back bursts are therefore separated by 1 cycle on m_axi_ar*.
- Simultaneous rlast of the current burst and a new request from the other master: handled by the next IDLE arbitration. Because last was just updated, the other master wins any tie.
- Reset mid-burst (ADDR or DATA):
  - Return to IDLE immediately (areset) or at the next edge (srst).
  - Remaining R beats of the abandoned burst are not forwarded.
  - The system resets the slave together with the arbiter.
- Backpressure: m_axi_rready follows s[grant]_axi_rready combinationally. A beat is never dropped or duplicated while rready is low.

## Test plan
- Single request: s0 arvalid, araddr = 0x0100, arlen = 0, arid = 0x11 → m_axi_arvalid 1 cycle later with addr 0x0100 and id 0x11. One R beat reaches s0 with rid = 0x11 and rlast = 1. s1_axi_rvalid stays 0 throughout.
- Tie after reset: s0 and s1 raise arvalid in the same cycle (0x0200 and 0x0300, arlen = 3) → s0 burst of 4 beats completes first. After 1 IDLE cycle, m_axi_araddr = 0x0300 and 4 beats reach s1 only.
- Fairness: s0 and s1 keep requesting continuously for 6 bursts → the m_axi_arid sequence alternates s0, s1, s0, s1, s0, s1.
- Blocking: s1 raises arvalid during an s0 DATA phase with arlen = 7 → s1_axi_arready stays 0 until 1 cycle after s0 rlast. The s1 AR is then issued.
- Backpressure: s0 rready toggles 1/0 every cycle during an 8-beat burst → m_axi_rready mirrors it. Exactly 8 beats arrive in order with rlast on the 8th.
- Reset mid-burst: areset pulse after beat 2 of a 4-beat s1 burst → all valid/ready outputs are 0 immediately. Next tie-break grants s0.
